// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator controller.
package serial_cmp_ctrl_pkg;

   // Default operand width; legal range is 2..32.
   localparam int DEF_WIDTH = 8;

   // Controller state encoding.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Result flag bundle in the order {eq, neq, big_a, big_b}.
   typedef struct packed {
      logic eq;
      logic neq;
      logic big_a;
      logic big_b;
   } flags_t;

endpackage

// File: rtl/serial_cmp_ctrl_cmp_bit.sv
// Purely combinational 1-bit magnitude comparator.
module cmp_bit (
   input  logic x,
   input  logic y,
   output logic eq,
   output logic gt,
   output logic lt
);

   // Exactly one of eq/gt/lt is high for any input pair.
   always_comb begin
      eq = ~(x ^ y);
      gt = x & ~y;
      lt = ~x & y;
   end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator controller.
// Walks two latched operands MSB-first through a single 1-bit comparator,
// stopping at the first differing bit or after bit 0.
//
// Handshake: start is sampled only while idle (busy=0); the accepting edge
// latches a/b and raises busy. done is a one-cycle pulse on the edge that
// also drops busy; eq/neq/big_a/big_b update on that edge and then hold
// until the next done. A start seen in the done cycle is accepted on the
// following edge, so back-to-back compares have no idle gap.
module serial_cmp_ctrl
   import serial_cmp_ctrl_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             neq,
   output logic             big_a,
   output logic             big_b,
   output logic             o_dbg_state
);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_busy;
   logic             r_done;
   flags_t           r_flags;

   logic             w_a_bit;
   logic             w_b_bit;
   logic             w_eq;
   logic             w_gt;
   logic             w_lt;

   // Select the bit pair under test from the latched operands.
   always_comb begin
      w_a_bit = r_a[r_idx];
      w_b_bit = r_b[r_idx];
   end

   cmp_bit u_cmp_bit (
      .x  (w_a_bit),
      .y  (w_b_bit),
      .eq (w_eq),
      .gt (w_gt),
      .lt (w_lt)
   );

   // Controller FSM: operand capture, index walk and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_flags <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_idx   <= IDX_W'(WIDTH - 1);
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!w_eq) begin
                  // First differing bit decides the ordering.
                  r_flags.eq    <= 1'b0;
                  r_flags.neq   <= 1'b1;
                  r_flags.big_a <= w_gt;
                  r_flags.big_b <= w_lt;
                  r_done        <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= ST_IDLE;
               end else if (r_idx == '0) begin
                  // Every bit matched.
                  r_flags.eq    <= 1'b1;
                  r_flags.neq   <= 1'b0;
                  r_flags.big_a <= 1'b0;
                  r_flags.big_b <= 1'b0;
                  r_done        <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= ST_IDLE;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Outputs are driven straight from registers.
   always_comb begin
      busy        = r_busy;
      done        = r_done;
      eq          = r_flags.eq;
      neq         = r_flags.neq;
      big_a       = r_flags.big_a;
      big_b       = r_flags.big_b;
      o_dbg_state = r_state;
   end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed, table-driven bench for serial_cmp_ctrl (WIDTH=8).
module tb_serial_cmp_ctrl;

   localparam int WIDTH = 8;

   // Flag encodings in the order {eq, neq, big_a, big_b}.
   localparam logic [3:0] F_EQ   = 4'b1000;
   localparam logic [3:0] F_BIGA = 4'b0110;
   localparam logic [3:0] F_BIGB = 4'b0101;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int               lat;
      logic [3:0]       flags;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             eq;
   logic             neq;
   logic             big_a;
   logic             big_b;
   logic             dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t vecs[10];

   serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .eq          (eq),
      .neq         (neq),
      .big_a       (big_a),
      .big_b       (big_b),
      .o_dbg_state (dbg_state)
   );

   // Clock and reset defaults.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] flags_now();
      return {eq, neq, big_a, big_b};
   endfunction

   function automatic logic [6:0] all_outs();
      return {busy, done, eq, neq, big_a, big_b, dbg_state};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one compare and measure latency, busy span, result and pulse width.
   // Entered and left at posedge+1.
   task automatic run_cmp(input string nm, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input int exp_lat,
                          input logic [3:0] exp_flags);
      int lat;
      int busy_cyc;
      start = 1'b1;
      a     = va;
      b     = vb;
      tick();
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      lat      = 0;
      busy_cyc = 0;
      for (int c = 1; c <= WIDTH + 4; c++) begin
         if (busy) busy_cyc++;
         tick();
         if (done) begin
            lat = c;
            break;
         end
      end
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      check({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
      check({nm, "_flags"}, 32'(flags_now()), 32'(exp_flags));
      check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
      tick();
      check({nm, "_done_pulse"}, 32'(done), 32'd0);
      check({nm, "_flags_hold"}, 32'(flags_now()), 32'(exp_flags));
   endtask

   initial begin
      int lat;
      // Directed vectors: latency = WIDTH - index of first differing bit.
      vecs[0] = '{8'h80, 8'h7F, 1, F_BIGA};
      vecs[1] = '{8'h12, 8'h13, 8, F_BIGB};
      vecs[2] = '{8'hA5, 8'hA5, 8, F_EQ};
      vecs[3] = '{8'h10, 8'h08, 4, F_BIGA};
      vecs[4] = '{8'h20, 8'h30, 4, F_BIGB};
      vecs[5] = '{8'hFF, 8'h00, 1, F_BIGA};
      vecs[6] = '{8'h00, 8'hFF, 1, F_BIGB};
      vecs[7] = '{8'h01, 8'h00, 8, F_BIGA};
      vecs[8] = '{8'h00, 8'h00, 8, F_EQ};
      vecs[9] = '{8'hC3, 8'hC7, 6, F_BIGB};

      // Reset with random inputs.
      rst_n = 1'b0;
      start = 1'($urandom);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      #2;
      check("reset_outputs", 32'(all_outs()), 32'd0);
      tick();
      tick();
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("idle_outputs_%0d", i), 32'(all_outs()), 32'd0);
      end

      // Table-driven compares.
      for (int i = 0; i < 10; i++) begin
         run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].flags);
      end

      // Busy protection: second start during RUN is ignored, not queued.
      start = 1'b1;
      a     = 8'h0F;
      b     = 8'h0E;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      a     = 8'h00;
      b     = 8'hFF;
      tick();
      start = 1'b0;
      lat   = 0;
      for (int c = 4; c <= WIDTH + 4; c++) begin
         tick();
         if (done) begin
            lat = c;
            break;
         end
      end
      check("busy_prot_latency", 32'(lat), 32'd8);
      check("busy_prot_flags", 32'(flags_now()), 32'(F_BIGA));
      lat = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done || busy) lat++;
      end
      check("busy_prot_no_second", 32'(lat), 32'd0);

      // Back-to-back: start held across done, new operands accepted right after.
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h08;
      tick();
      a     = 8'h40;
      b     = 8'h40;
      lat   = 0;
      for (int c = 1; c <= WIDTH + 4; c++) begin
         tick();
         if (done) begin
            lat = c;
            break;
         end
      end
      check("b2b_first_latency", 32'(lat), 32'd4);
      check("b2b_first_flags", 32'(flags_now()), 32'(F_BIGA));
      tick();
      start = 1'b0;
      check("b2b_no_gap_busy", 32'(busy), 32'd1);
      check("b2b_no_gap_done", 32'(done), 32'd0);
      lat = 0;
      for (int c = 1; c <= WIDTH + 4; c++) begin
         if (!done && flags_now() !== F_BIGA) begin
            check($sformatf("b2b_hold_%0d", c), 32'(flags_now()), 32'(F_BIGA));
         end
         tick();
         if (done) begin
            lat = c;
            break;
         end
      end
      check("b2b_second_latency", 32'(lat), 32'd8);
      check("b2b_second_flags", 32'(flags_now()), 32'(F_EQ));

      // Reset during RUN abandons the compare.
      tick();
      start = 1'b1;
      a     = 8'h55;
      b     = 8'h55;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("midrun_busy", 32'(busy), 32'd1);
      check("midrun_flags_hold", 32'(flags_now()), 32'(F_EQ));
      rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs", 32'(all_outs()), 32'd0);
      tick();
      rst_n = 1'b1;
      lat = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (all_outs() !== 7'd0) lat++;
      end
      check("midrun_no_done_after", 32'(lat), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case a wait above is ever miscounted.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
